down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Synchronous loadable down-counter/timer. It is the counting-down counterpart of the team's mod-31 up-counter and uses the same range (0..30).
- Counts from a parallel-loaded value down to 0 and raises a one-cycle registered borrow pulse at 0.
- Either auto-reloads from a captured reload register or stops (one-shot mode).
- Cascadable through EN/ET and a terminal-count output, so it can feed prescalers and delay timers in the lab designs.

Parameters:
WIDTH, 5, counter/data width in bits
MODULUS, 31, count range is 0..MODULUS-1; MODULUS <= 2**WIDTH

Ports:
CLK  input  1  rising-edge clock
RD  input  1  reset; one clock; reset is asynchronous and active-high
LD  input  1  synchronous parallel load, active-high
EN  input  1  count enable (parallel enable)
ET  input  1  count enable (trickle/cascade enable, also gates TC)
MODE  input  1  0 = auto-reload, 1 = one-shot
D  input  WIDTH  load value
Q  output  WIDTH  current count, registered
B  output  1  borrow pulse, registered, high for exactly one cycle
TC  output  1  terminal count, combinational: (Q==0) & ET & (state==RUN)
BUSY  output  1  registered, high when state==RUN

Behaviour:
- State machine: RUN, HALT. Registered state; BUSY = (state==RUN).
- Reset (RD=1, asynchronous, overrides everything): Q=0, reload register R=MODULUS-1, B=0, state=RUN. All outputs known immediately; Q is never X.
- Priority at each rising CLK edge with RD=0: LD > count > hold.
- LD=1:
  - Captured value V = D; if D > MODULUS-1, V = MODULUS-1 (clamp).
  - Q<=V, R<=V, B<=0, state<=RUN.
  - LD is independent of EN/ET and MODE.
- Count (LD=0, EN=1, ET=1, state=RUN):
  - Q != 0: Q<=Q-1, B<=0.
  - Q == 0, MODE=0: Q<=R, B<=1, state stays RUN (auto-reload wrap).
  - Q == 0, MODE=1: Q stays 0, B<=1, state<=HALT.
- Hold (LD=0 and (EN=0 or ET=0)): Q, R and state hold; B<=0.
- HALT: Q holds 0, B<=0 every cycle, TC=0. Only LD or RD leaves HALT.
- Period in auto-reload mode is R+1 enabled cycles between B pulses. R=0 gives B high on every enabled cycle with Q constantly 0.
- MODE is sampled only on the edge where Q==0 is counted. Changing MODE mid-count has no other effect.
- Simultaneous LD and count-at-zero: LD wins, no B pulse.
- RD asserted mid-count: immediate return to reset values; a B pulse in flight is cleared.
- Cascade: the next stage's ET is driven from this stage's TC. TC is combinational from registers only; it has no path from D, LD or MODE.
- Arithmetic: decrement is WIDTH-bit unsigned. Underflow never occurs because the zero case is handled explicitly.

Decomposition:
- Shared package: state encoding constants (ST_RUN=1'b0, ST_HALT=1'b1), default WIDTH/MODULUS constants shared with the up-counter, and the MODE encodings (MODE_RELOAD=0, MODE_ONESHOT=1).
- One natural sub-module, down_counter_ctrl: the RUN/HALT FSM plus the B/BUSY registers. The datapath (Q, R, clamp, decrement) stays in the top level.

Test Plan:
- Reset then auto-reload: RD pulse; EN=ET=1, MODE=0, no LD. Cycle 1: B=1, Q=30. Q then counts 29..0 and the next B is 31 cycles after the first.
- Load and count down: LD with D=5, MODE=0. Q goes 5,4,3,2,1,0. TC=1 while Q=0. On the next edge B=1 for one cycle and Q=5 (reload from R).
- One-shot: LD with D=3, MODE=1. Q goes 3,2,1,0, then B=1 for one cycle, BUSY=0, and Q holds 0 for 10+ cycles. A new LD with D=2 restarts: BUSY=1, Q=2.
- Clamp and hold: LD with D=31, giving Q=30. Toggle ET=0 for 4 cycles: Q holds, B=0, TC=0. Hold EN=0 while Q=0: B stays 0.
- Collisions: at Q=0 with MODE=0, assert LD with D=7 on the same edge. Required result: Q=7, B=0. Then assert RD asynchronously mid-cycle while Q=4: Q=0, B=0, BUSY=1 before the next CLK edge.
- Cascade: two instances, stage 2 ET tied to stage 1 TC, both loaded with D=2. Stage 2 decrements only on stage-1 wrap edges. Stage 2 issues B after (2+1)*(2+1)=9 enabled cycles.

Source files
------------

// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared constants for the down-counter timer
//
// Purpose: state encodings, mode encodings and the default width/range
// shared with the mod-31 up-counter.
// Ports: none (package).
package down_counter_pkg;

  localparam int DC_WIDTH   = 5;
  localparam int DC_MODULUS = 31;

  // RUN/HALT state encoding (kept as plain constants for legacy netlists)
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // MODE input encodings
  localparam logic MODE_RELOAD  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/down_counter_if.sv
// rtl/down_counter_if.sv - control/status bundle of the down-counter timer
//
// Purpose: groups load/enable/mode inputs and count/status outputs.
// Signals: LD, EN, ET, MODE, D (to counter); Q, B, TC, BUSY (from counter).
// Modports: master drives controls and observes status; slave is the counter.
interface down_counter_if
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DC_WIDTH
);

  logic             LD;
  logic             EN;
  logic             ET;
  logic             MODE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             B;
  logic             TC;
  logic             BUSY;

  modport master (
    output LD, EN, ET, MODE, D,
    input  Q, B, TC, BUSY
  );

  modport slave (
    input  LD, EN, ET, MODE, D,
    output Q, B, TC, BUSY
  );

endinterface

// File: rtl/down_counter_ctrl.sv
// rtl/down_counter_ctrl.sv - RUN/HALT state machine and borrow register
//
// Purpose: decides when the datapath counts, tracks one-shot completion and
// produces the registered one-cycle borrow pulse.
// Ports:
//   CLK      rising-edge clock
//   RD       asynchronous active-high reset
//   ld       synchronous load request
//   en, et   parallel and trickle count enables
//   mode     0 = auto-reload, 1 = one-shot (sampled only when counting at zero)
//   at_zero  current count is zero
//   count_en datapath may count on this edge
//   run      state is RUN (drives BUSY and gates TC)
//   b        registered borrow pulse
module down_counter_ctrl
  import down_counter_pkg::*;
(
  input  logic CLK,
  input  logic RD,
  input  logic ld,
  input  logic en,
  input  logic et,
  input  logic mode,
  input  logic at_zero,
  output logic count_en,
  output logic run,
  output logic b
);

  logic [0:0] state;

  assign run      = (state == ST_RUN);
  // Load has priority, so a load edge is never a count edge.
  assign count_en = !ld && en && et && run;

  always_ff @(posedge CLK or posedge RD) begin
    if (RD) begin
      state <= ST_RUN;
      b     <= 1'b0;
    end else if (ld) begin
      state <= ST_RUN;
      b     <= 1'b0;
    end else if (count_en && at_zero) begin
      b <= 1'b1;
      if (mode == MODE_ONESHOT) begin
        state <= ST_HALT;
      end
    end else begin
      b <= 1'b0;
    end
  end

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable cascadable down-counter/timer (0..MODULUS-1)
//
// Purpose: counts from a loaded value to zero, pulses B on the zero count,
// then reloads from the captured reload value or halts (one-shot).
// Ports:
//   CLK  rising-edge clock
//   RD   asynchronous active-high reset
//   bus  slave side of down_counter_if: LD, EN, ET, MODE, D in;
//        Q (count), B (borrow pulse), TC (terminal count), BUSY out
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH   = DC_WIDTH,
  parameter int MODULUS = DC_MODULUS
) (
  input  logic          CLK,
  input  logic          RD,
  down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] ld_val;
  logic             at_zero;
  logic             count_en;
  logic             run;

  assign at_zero = (q == '0);
  // Out-of-range load values saturate to the top of the count range.
  assign ld_val  = (bus.D > MAX_V) ? MAX_V : bus.D;

  down_counter_ctrl u_ctrl (
    .CLK      (CLK),
    .RD       (RD),
    .ld       (bus.LD),
    .en       (bus.EN),
    .et       (bus.ET),
    .mode     (bus.MODE),
    .at_zero  (at_zero),
    .count_en (count_en),
    .run      (run),
    .b        (bus.B)
  );

  always_ff @(posedge CLK or posedge RD) begin
    if (RD) begin
      q <= '0;
      r <= MAX_V;
    end else if (bus.LD) begin
      q <= ld_val;
      r <= ld_val;
    end else if (count_en) begin
      if (!at_zero) begin
        q <= q - WIDTH'(1);
      end else if (bus.MODE == MODE_RELOAD) begin
        q <= r;
      end
      // one-shot at zero: q stays 0 while the FSM halts
    end
  end

  assign bus.Q    = q;
  // Built from registers and ET only, so cascades see no path from D/LD/MODE.
  assign bus.TC   = at_zero & bus.ET & run;
  assign bus.BUSY = run;

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - scoreboard testbench for down_counter
module tb_down_counter;

  localparam int MOD = 31;

  logic CLK;
  logic RD;
  logic RDc;

  down_counter_if bus0 ();
  down_counter_if bus1 ();
  down_counter_if bus2 ();

  down_counter u0 (.CLK(CLK), .RD(RD),  .bus(bus0));
  down_counter u1 (.CLK(CLK), .RD(RDc), .bus(bus1));
  down_counter u2 (.CLK(CLK), .RD(RDc), .bus(bus2));

  assign bus2.ET = bus1.TC;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int q;
    bit b;
    bit busy;
    bit tc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference model: count value, reload value, running flag
  int mq, mr, mb;
  bit mrun;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit rd, input bit ld, input bit en,
                                     input bit et, input bit mode, input int d);
    if (rd) begin
      mq = 0; mr = MOD - 1; mb = 0; mrun = 1;
    end else if (ld) begin
      mq = (d > MOD - 1) ? MOD - 1 : d;
      mr = mq; mb = 0; mrun = 1;
    end else if (en && et && mrun) begin
      if (mq > 0) begin
        mq = mq - 1; mb = 0;
      end else begin
        mb = 1;
        if (mode) mrun = 0;
        else      mq = mr;
      end
    end else begin
      mb = 0;
    end
  endfunction

  function automatic void push(input bit et);
    exp_t e;
    e.q = mq; e.b = (mb != 0); e.busy = mrun;
    e.tc = (mq == 0) && et && mrun;
    sbq.push_back(e);
  endfunction

  task automatic step(input bit rd, input bit ld, input bit en, input bit et,
                      input bit mode, input int d);
    @(negedge CLK);
    RD = rd; bus0.LD = ld; bus0.EN = en; bus0.ET = et; bus0.MODE = mode;
    bus0.D = 5'(d);
    model_edge(rd, ld, en, et, mode, d);
    push(et);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  // monitor: every edge the counter presents a new output set
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp("sb_q",    int'(bus0.Q),    e.q);
        cmp("sb_b",    int'(bus0.B),    int'(e.b));
        cmp("sb_busy", int'(bus0.BUSY), int'(e.busy));
        cmp("sb_tc",   int'(bus0.TC),   int'(e.tc));
      end
    end
  end

  initial begin
    int  k;
    bit  found;
    bit  rmode;
    RD = 1'b1; RDc = 1'b1;
    bus0.LD = 0; bus0.EN = 0; bus0.ET = 0; bus0.MODE = 0; bus0.D = '0;
    bus1.LD = 0; bus1.EN = 0; bus1.ET = 0; bus1.MODE = 0; bus1.D = '0;
    bus2.LD = 0; bus2.EN = 0; bus2.MODE = 0; bus2.D = '0;
    #1;
    cmp("rst_q", int'(bus0.Q), 0);
    cmp("rst_b", int'(bus0.B), 0);
    cmp("rst_busy", int'(bus0.BUSY), 1);
    model_edge(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);

    // reset then auto-reload: first enabled edge wraps to 30 with B
    step(0, 0, 1, 1, 0, 0); settle();
    cmp("first_q", int'(bus0.Q), 30);
    cmp("first_b", int'(bus0.B), 1);
    found = 0; k = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step(0, 0, 1, 1, 0, 0); settle();
      if (bus0.B) begin found = 1; k = i; end
    end
    cmp("period", k, 31);

    // load 5 and count down with reload
    step(0, 1, 1, 1, 0, 5);
    repeat (5) step(0, 0, 1, 1, 0, 0);
    settle();
    cmp("ld5_zero_tc", int'(bus0.TC), 1);
    step(0, 0, 1, 1, 0, 0); settle();
    cmp("ld5_reload_q", int'(bus0.Q), 5);
    cmp("ld5_reload_b", int'(bus0.B), 1);

    // one-shot
    step(0, 1, 1, 1, 1, 3);
    repeat (4) step(0, 0, 1, 1, 1, 0);
    settle();
    cmp("os_b", int'(bus0.B), 1);
    cmp("os_busy", int'(bus0.BUSY), 0);
    repeat (10) step(0, 0, 1, 1, 1, 0);
    settle();
    cmp("os_hold_q", int'(bus0.Q), 0);
    cmp("os_hold_b", int'(bus0.B), 0);
    cmp("os_hold_tc", int'(bus0.TC), 0);
    step(0, 1, 1, 1, 1, 2); settle();
    cmp("os_restart_busy", int'(bus0.BUSY), 1);
    cmp("os_restart_q", int'(bus0.Q), 2);

    // clamp and hold
    step(0, 1, 1, 1, 0, 31); settle();
    cmp("clamp_q", int'(bus0.Q), 30);
    repeat (4) step(0, 0, 1, 0, 0, 0);
    settle();
    cmp("et_hold_q", int'(bus0.Q), 30);
    cmp("et_hold_b", int'(bus0.B), 0);
    cmp("et_hold_tc", int'(bus0.TC), 0);
    step(0, 1, 1, 1, 0, 1);
    step(0, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    settle();
    cmp("en_hold_q", int'(bus0.Q), 0);
    cmp("en_hold_b", int'(bus0.B), 0);

    // load collides with count at zero: load wins
    step(0, 1, 1, 1, 0, 7); settle();
    cmp("coll_q", int'(bus0.Q), 7);
    cmp("coll_b", int'(bus0.B), 0);

    // asynchronous reset mid-cycle at Q=4
    repeat (3) step(0, 0, 1, 1, 0, 0);
    @(negedge CLK);
    bus0.LD = 0; bus0.EN = 1; bus0.ET = 1; bus0.MODE = 0;
    #1 RD = 1'b1;
    #1;
    cmp("async_q", int'(bus0.Q), 0);
    cmp("async_b", int'(bus0.B), 0);
    cmp("async_busy", int'(bus0.BUSY), 1);
    RD = 1'b0;
    model_edge(1, 0, 0, 0, 0, 0);
    model_edge(0, 0, 1, 1, 0, 0);
    push(1);

    // randomized traffic
    rmode = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) rmode = ~rmode;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
           rmode, int'($urandom_range(0, 31)));
    end
    step(0, 0, 0, 0, 0, 0);

    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (sbq.size() == 0) found = 1;
      else @(posedge CLK);
    end
    #2;
    cmp("sb_drain", sbq.size(), 0);

    // cascade: stage 2 counts only on stage 1 terminal count
    @(negedge CLK);
    RDc = 1'b0;
    bus1.LD = 1; bus1.D = 5'd2; bus1.EN = 1; bus1.ET = 1;
    bus2.LD = 1; bus2.D = 5'd2; bus2.EN = 1;
    @(negedge CLK);
    bus1.LD = 0; bus2.LD = 0;
    found = 0; k = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(posedge CLK);
      #1;
      if (bus2.B) begin found = 1; k = i; end
    end
    cmp("cascade_period", k, 9);
    cmp("cascade_q2_reload", int'(bus2.Q), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
